// File: rtl/machine_adder_arbiter.sv
// machine_adder_arbiter: round-robin sharing of one 2-bit adder between NREQ requesters
// Grants one request per IDLE, drives its operand in EXEC, and holds the result in RESP until it is taken.
module machine_adder_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_sw,
  output logic [NREQ-1:0]   req_ready,
  output logic [1:0]        add_sw,
  input  logic [1:0]        add_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [1:0]        rsp_result,
  output logic [7:0]        done_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t          r_state, w_next;
  logic [ID_W-1:0] r_last, r_id, r_rid, w_win, w_c;
  logic [1:0]      r_op, r_res;
  logic            r_vld, w_any;
  logic [7:0]      r_done;
  logic [1:0]      w_ops [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign w_ops[g] = req_sw[2*g+1:2*g];
  end
  // Walk last_grant+1, +2, ... with an explicit wrap so non-power-of-two NREQ works.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_c = r_last;
    for (int k = 0; k < NREQ; k++) begin
      w_c = (w_c == ID_W'(NREQ-1)) ? '0 : w_c + 1'b1;
      if (!w_any && req_valid[w_c]) begin
        w_win = w_c;
        w_any = 1'b1;
      end
    end
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (w_any ? EXEC : IDLE) :
             (r_state == EXEC) ? RESP : (rsp_ready ? IDLE : RESP);
  end
  assign req_ready  = (r_state == IDLE && w_any) ? {{(NREQ-1){1'b0}}, 1'b1} << w_win : '0;
  assign add_sw     = (r_state == EXEC) ? r_op : 2'b00;
  assign rsp_valid  = r_vld;
  assign rsp_id     = r_rid;
  assign rsp_result = r_res;
  assign done_count = r_done;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= ID_W'(NREQ-1);
      r_id    <= '0;
      r_rid   <= '0;
      r_op    <= 2'b00;
      r_res   <= 2'b00;
      r_vld   <= 1'b0;
      r_done  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_op <= w_ops[w_win];
        r_id <= w_win;
      end
      if (r_state == EXEC) begin
        r_res <= add_result;
        r_rid <= r_id;
        r_vld <= 1'b1;
      end
      if (r_state == RESP && rsp_ready) begin
        r_vld  <= 1'b0;
        r_last <= r_id;
        r_done <= r_done + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_machine_adder_arbiter.sv
// tb_machine_adder_arbiter: vector table plus hand-written corner sequences; responses checked from a queue
module tb_machine_adder_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0;
  logic [3:0] req_valid = '0, req_ready;
  logic [7:0] req_sw = '0, done_count;
  logic [1:0] add_sw, add_result, rsp_id, rsp_result;
  logic       rsp_valid;
  int         errs = 0, checks = 0, exp_done = 0;
  logic [3:0] exp_q [$];
  logic [3:0] e;
  typedef struct {logic [3:0] m; logic [7:0] sw; int id; logic [1:0] res;} vec_t;
  vec_t tab [8];

  machine_adder_arbiter #(.NREQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sw(req_sw), .req_ready(req_ready),
    .add_sw(add_sw), .add_result(add_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .done_count(done_count)
  );

  always #5 clk = ~clk;
  assign add_result = {add_sw[1] & add_sw[0], add_sw[1] ^ add_sw[0]};

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL rsp_unexpected: got id %0d result %0h, expected no response", rsp_id, rsp_result);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e[3:2]));
        chk("rsp_result", 32'(rsp_result), 32'(e[1:0]));
        exp_done++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    tick;
    tick;
    rst_n = 1'b1;
    exp_done = 0;
  endtask

  task automatic txn(input logic [3:0] m, input logic [7:0] sw, input int id, input logic [1:0] res, input bit push);
    int t;
    req_valid = m;
    req_sw = sw;
    #1;
    t = 0;
    while (req_ready == 4'b0 && t < 10) begin
      tick;
      t++;
    end
    chk("req_ready", 32'(req_ready), 32'(4'b0001 << id));
    if (push) exp_q.push_back({id[1:0], res});
    tick;
    chk("add_sw", 32'(add_sw), 32'(sw[2*id +: 2]));
  endtask

  task automatic txn_full(input logic [3:0] m, input logic [7:0] sw, input int id, input logic [1:0] res);
    txn(m, sw, id, res, 1'b1);
    tick;
    tick;
  endtask

  initial begin
    #100000;
    errs++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] sw;
    logic [1:0] op, res;
    tab[0] = '{4'hf, 8'b11100100, 0, 2'b00};
    tab[1] = '{4'hf, 8'b11100100, 1, 2'b01};
    tab[2] = '{4'hf, 8'b11100100, 2, 2'b01};
    tab[3] = '{4'hf, 8'b11100100, 3, 2'b10};
    tab[4] = '{4'hf, 8'b11100100, 0, 2'b00};
    tab[5] = '{4'h8, 8'b11100100, 3, 2'b10};
    tab[6] = '{4'h9, 8'b11100100, 0, 2'b00};
    tab[7] = '{4'h6, 8'b11100100, 1, 2'b01};
    do_reset;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_done", 32'(done_count), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_add_sw", 32'(add_sw), 0);
    // single request from requester 1 after reset
    req_valid = 4'b0010;
    req_sw = 8'b00001100;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'(4'b0010));
    exp_q.push_back({2'd1, 2'b10});
    tick;
    chk("t1_add_sw", 32'(add_sw), 32'(2'b11));
    chk("t1_exec_ready", 32'(req_ready), 0);
    req_valid = '0;
    tick;
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 1);
    chk("t1_rsp_result", 32'(rsp_result), 32'(2'b10));
    rsp_ready = 1'b1;
    tick;
    chk("t1_done", 32'(done_count), 1);
    chk("t1_rsp_cleared", 32'(rsp_valid), 0);
    // round-robin order and wrap from a fresh reset
    do_reset;
    for (int i = 0; i < 8; i++) txn_full(tab[i].m, tab[i].sw, tab[i].id, tab[i].res);
    chk("tab_done", 32'(done_count), 32'(8'(exp_done)));
    // response back-pressure
    rsp_ready = 1'b0;
    txn(4'b0100, 8'b11100100, 2, 2'b01, 1'b1);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_id", 32'(rsp_id), 2);
      chk("stall_result", 32'(rsp_result), 1);
      chk("stall_ready", 32'(req_ready), 0);
      chk("stall_done", 32'(done_count), 8);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    chk("stall_done_after", 32'(done_count), 9);
    chk("stall_rsp_cleared", 32'(rsp_valid), 0);
    // reset during EXEC drops the request; still-valid requester is granted again
    txn(4'b1000, 8'b11100100, 3, 2'b10, 1'b0);
    rst_n = 1'b0;
    tick;
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_done", 32'(done_count), 0);
    chk("abort_idle_ready", 32'(req_ready), 32'(4'b1000));
    chk("abort_add_sw", 32'(add_sw), 0);
    rst_n = 1'b1;
    exp_done = 0;
    txn_full(4'b1000, 8'b11100100, 3, 2'b10);
    chk("abort_regrant_done", 32'(done_count), 1);
    // done_count wrap after 256 completions
    do_reset;
    for (int k = 0; k < 256; k++) begin
      sw = 8'($urandom);
      op = sw[2*(k%4) +: 2];
      res = {1'b0, op[1]} + {1'b0, op[0]};
      txn_full(4'hf, sw, k % 4, res);
      if (k == 254) chk("wrap_255", 32'(done_count), 255);
    end
    chk("wrap_zero", 32'(done_count), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
